monitor_consola_uart: RTL and testbench

- Hardware counterpart of the console-monitor testbench: watches a DUT's input and output vectors on the board and prints them as ASCII text lines over UART 8N1 to a PC terminal.
- Prints a header once after reset, then one line each time the monitored values change.
- Sits beside the circuit under test on the FPGA top level; its tx pin goes to the USB-UART bridge.

---
 rtl/consola_pkg.sv | 25 ++
 rtl/uart_tx_byte.sv | 57 +++++
 rtl/monitor_consola_uart.sv | 133 +++++++++++++
 tb/tb_monitor_consola_uart.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/consola_pkg.sv
// Shared constants for the UART console monitor: ASCII codes, FSM states
// and the baud divisor helper.
package consola_pkg;

    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_BAR  = 8'h7C;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ESPERA_CAB,
        CABECERA,
        CAPTURA,
        LINEA,
        REPOSO
    } estado_t;

    function automatic int div_baudios(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter with its own baud and bit counters.
// Handshake: a byte is taken on any cycle where inicio=1 and listo=1. listo is
// high when idle and also in the last clock of the stop bit, so a byte offered
// then starts its start bit with no idle gap.
module uart_tx_byte #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dato,
    input  logic       inicio,
    output logic       tx,
    output logic       listo
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    sr;
    logic          activo;

    assign listo = !activo || (bit_idx == 4'd9 && cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx      <= 1'b1;
            activo  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            sr      <= '1;
        end else if (inicio && listo) begin
            tx      <= 1'b0;
            sr      <= {1'b1, dato};
            cnt     <= '0;
            bit_idx <= '0;
            activo  <= 1'b1;
        end else if (activo) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    activo <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    // sr carries the stop bit in at the top, so bit 9 shifts out a 1
                    tx      <= sr[0];
                    sr      <= {1'b1, sr[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/monitor_consola_uart.sv
// Prints a header after reset and then one ASCII line per change of the
// monitored {entradas, salidas} vectors over a UART 8N1 link.
module monitor_consola_uart #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  entradas,
    input  logic [N_OUT-1:0] salidas,
    input  logic             habilitar,
    output logic             tx,
    output logic             ocupado
);
    import consola_pkg::*;

    localparam int DIV = div_baudios(CLK_HZ, BAUD);
    localparam int NS  = N_IN + N_OUT;
    localparam int HL  = 2*N_IN + N_OUT + 4;
    localparam int LL  = 2*N_IN + N_OUT + 5;
    localparam logic [5:0] HL_IDX = 6'(HL);
    localparam logic [5:0] LL_IDX = 6'(LL);

    estado_t         estado;
    logic [5:0]      idx;
    logic [NS-1:0]   snap;
    logic            inicio;
    logic            listo;
    logic [7:0]      caracter;

    assign inicio = (estado == CABECERA && idx < HL_IDX) ||
                    (estado == LINEA    && idx < LL_IDX);

    always_comb begin
        int i;
        logic [N_IN-1:0]  sh_in;
        logic [N_OUT-1:0] sh_out;
        i        = int'(idx);
        sh_in    = '0;
        sh_out   = '0;
        caracter = CH_LF;
        if (estado == CABECERA) begin
            if (i < 2*N_IN)       caracter = CH_DASH;
            else if (i == 2*N_IN) caracter = CH_BAR;
            else if (i < HL-2)    caracter = CH_DASH;
            else if (i == HL-2)   caracter = CH_CR;
            else                  caracter = CH_LF;
        end else begin
            // Input field is pairs of (space, bit) starting at the MSB
            if (i < 2*N_IN) begin
                sh_in    = snap[NS-1:N_OUT] >> (N_IN - 1 - i/2);
                caracter = i[0] ? (sh_in[0] ? CH_1 : CH_0) : CH_SP;
            end else if (i == 2*N_IN + 1) begin
                caracter = CH_BAR;
            end else if (i < 2*N_IN + 3) begin
                caracter = CH_SP;
            end else if (i < LL-2) begin
                sh_out   = snap[N_OUT-1:0] >> (LL - 3 - i);
                caracter = sh_out[0] ? CH_1 : CH_0;
            end else if (i == LL-2) begin
                caracter = CH_CR;
            end else begin
                caracter = CH_LF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado  <= ESPERA_CAB;
            idx     <= '0;
            snap    <= '0;
            ocupado <= 1'b0;
        end else begin
            case (estado)
                ESPERA_CAB: begin
                    estado  <= CABECERA;
                    idx     <= '0;
                    ocupado <= 1'b1;
                end
                CABECERA: begin
                    if (listo) begin
                        if (idx < HL_IDX) begin
                            idx <= idx + 6'd1;
                        end else begin
                            // last stop bit ends this cycle
                            idx    <= '0;
                            estado <= CAPTURA;
                        end
                    end
                end
                CAPTURA: begin
                    snap   <= {entradas, salidas};
                    idx    <= '0;
                    estado <= LINEA;
                end
                LINEA: begin
                    if (listo) begin
                        if (idx < LL_IDX) begin
                            idx <= idx + 6'd1;
                        end else begin
                            idx     <= '0;
                            estado  <= REPOSO;
                            ocupado <= 1'b0;
                        end
                    end
                end
                REPOSO: begin
                    if (habilitar && ({entradas, salidas} != snap)) begin
                        estado  <= CAPTURA;
                        ocupado <= 1'b1;
                    end
                end
                default: begin
                    estado  <= ESPERA_CAB;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk    (clk),
        .rst    (rst),
        .dato   (caracter),
        .inicio (inicio),
        .tx     (tx),
        .listo  (listo)
    );

endmodule

// File: tb/tb_monitor_consola_uart.sv
// Bench for monitor_consola_uart: a UART decoder pops expected characters from
// a scoreboard queue filled by the scenario tasks.
module tb_monitor_consola_uart;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 1;
    localparam int DIV    = CLK_HZ / BAUD;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_IN-1:0]  entradas = '0;
    logic [N_OUT-1:0] salidas = '0;
    logic             habilitar = 1'b1;
    logic             tx;
    logic             ocupado;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    logic [7:0] exp_q[$];
    int t_q[$];

    monitor_consola_uart #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .N_IN   (N_IN),
        .N_OUT  (N_OUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .entradas  (entradas),
        .salidas   (salidas),
        .habilitar (habilitar),
        .tx        (tx),
        .ocupado   (ocupado)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // driver helpers
    task automatic push_header();
        for (int k = 0; k < 2*N_IN; k++) exp_q.push_back(8'h2D);
        exp_q.push_back(8'h7C);
        for (int k = 0; k < N_OUT+1; k++) exp_q.push_back(8'h2D);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_line(input logic [N_IN-1:0] e, input logic [N_OUT-1:0] s);
        for (int k = N_IN-1; k >= 0; k--) begin
            exp_q.push_back(8'h20);
            exp_q.push_back(e[k] ? 8'h31 : 8'h30);
        end
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h7C);
        exp_q.push_back(8'h20);
        for (int k = N_OUT-1; k >= 0; k--) exp_q.push_back(s[k] ? 8'h31 : 8'h30);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic esperar_cola(input int max_ciclos, output bit ok);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_ciclos) begin
            @(negedge clk);
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    // scoreboard side: serial decoder sampling mid-bit on the falling clock edge
    task automatic decodificador();
        logic [7:0] c;
        logic [7:0] e;
        int p;
        int b;
        bit busy;
        busy = 1'b0;
        p = 0;
        c = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (tx === 1'b0) begin
                    busy = 1'b1;
                    p = 0;
                    t_q.push_back(cyc);
                end
            end else begin
                p++;
                if (p % DIV == DIV/2) begin
                    b = p / DIV;
                    if (b == 0) begin
                        if (tx !== 1'b0) begin
                            errors++;
                            $display("FAIL rx_start: got tx=%b required 0 at cycle %0d", tx, cyc);
                            busy = 1'b0;
                        end
                    end else if (b <= 8) begin
                        c[b-1] = tx;
                    end else begin
                        busy = 1'b0;
                        checks++;
                        if (tx !== 1'b1) begin
                            errors++;
                            $display("FAIL rx_stop: got tx=%b required 1, char 0x%02h", tx, c);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rx_unexpected: got char 0x%02h required none", c);
                        end else begin
                            e = exp_q.pop_front();
                            if (c !== e) begin
                                errors++;
                                $display("FAIL rx_char: got 0x%02h required 0x%02h", c, e);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        int c0;
        int n;
        int bad;
        rst = 1'b1;
        entradas = 2'b01;
        salidas = 1'b1;
        habilitar = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b required 0", ocupado); end
        push_header();
        push_line(2'b01, 1'b1);
        c0 = cyc;
        rst = 1'b0;
        n = 0;
        bad = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
            if (ocupado !== 1'b1) bad++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL first_output_timeout: got %0d pending required 0", exp_q.size()); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ocupado_during_header: got %0d low cycles required 0", bad); end
        repeat (10) @(negedge clk);
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL ocupado_after_line: got %b required 0", ocupado); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after_line: got %b required 1", tx); end
        checks++;
        if (t_q.size() != 19) begin
            errors++;
            $display("FAIL first_char_count: got %0d required 19", t_q.size());
        end else begin
            checks++;
            if (t_q[0] - c0 != 2) begin errors++; $display("FAIL header_start_latency: got %0d required 2", t_q[0] - c0); end
            checks++;
            if (t_q[8] - t_q[0] != 8*10*DIV) begin errors++; $display("FAIL header_back_to_back: got %0d required %0d", t_q[8] - t_q[0], 8*10*DIV); end
            checks++;
            if (t_q[9] - t_q[8] != 10*DIV + 2) begin errors++; $display("FAIL header_to_line_gap: got %0d required %0d", t_q[9] - t_q[8], 10*DIV + 2); end
            checks++;
            if (t_q[18] - t_q[9] != 9*10*DIV) begin errors++; $display("FAIL line_back_to_back: got %0d required %0d", t_q[18] - t_q[9], 9*10*DIV); end
        end
    endtask

    task automatic test_cambio();
        int lat;
        base = t_q.size();
        push_line(2'b10, 1'b1);
        entradas = 2'b10;
        lat = 0;
        while (tx === 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL change_latency: got %0d required 3", lat); end
    endtask

    task automatic test_cambios_en_linea();
        bit ok;
        repeat (250) @(negedge clk);
        checks++;
        if (ocupado !== 1'b1) begin errors++; $display("FAIL ocupado_mid_line: got %b required 1", ocupado); end
        entradas = 2'b11;
        repeat (250) @(negedge clk);
        entradas = 2'b00;
        salidas = 1'b0;
        push_line(2'b00, 1'b0);
        esperar_cola(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL changes_during_line_timeout: got %0d pending required 0", exp_q.size()); end
        repeat (10) @(negedge clk);
        checks++;
        if (t_q.size() != base + 20) begin
            errors++;
            $display("FAIL changes_during_line_count: got %0d required %0d", t_q.size() - base, 20);
        end else begin
            checks++;
            if (t_q[base+10] - t_q[base+9] != 10*DIV + 3) begin
                errors++;
                $display("FAIL line_to_line_gap: got %0d required %0d", t_q[base+10] - t_q[base+9], 10*DIV + 3);
            end
        end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL ocupado_after_second_line: got %b required 0", ocupado); end
    endtask

    task automatic test_habilitar();
        int n_rx;
        int bad;
        int lat;
        bit ok;
        habilitar = 1'b0;
        salidas = 1'b1;
        n_rx = t_q.size();
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || ocupado !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL disabled_quiet: got %0d active cycles required 0", bad); end
        checks++;
        if (t_q.size() != n_rx) begin errors++; $display("FAIL disabled_no_chars: got %0d required 0", t_q.size() - n_rx); end
        push_line(2'b00, 1'b1);
        habilitar = 1'b1;
        lat = 0;
        while (tx === 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL enable_latency: got %0d required 3", lat); end
        esperar_cola(1500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL enable_line_timeout: got %0d pending required 0", exp_q.size()); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_linea();
        int n;
        bit ok;
        base = t_q.size();
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h20);
        entradas = 2'b11;
        n = 0;
        while (t_q.size() < base + 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (t_q.size() != base + 4) begin errors++; $display("FAIL fourth_char_start: got %0d required 4", t_q.size() - base); end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_start_bit: got %b required 0", tx); end
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b required 1", tx); end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL async_reset_ocupado: got %b required 0", ocupado); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL chars_before_reset: got %0d pending required 0", exp_q.size()); end
        exp_q.delete();
        repeat (5) @(negedge clk);
        push_header();
        push_line(2'b11, 1'b1);
        rst = 1'b0;
        esperar_cola(4000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL header_after_reset_timeout: got %0d pending required 0", exp_q.size()); end
        repeat (10) @(negedge clk);
        checks++;
        if (t_q.size() != base + 4 + 19) begin errors++; $display("FAIL chars_after_reset: got %0d required 19", t_q.size() - base - 4); end
    endtask

    task automatic test_reposo_largo();
        int n_rx;
        int bad;
        n_rx = t_q.size();
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_tx: got %0d low cycles required 0", bad); end
        checks++;
        if (t_q.size() != n_rx) begin errors++; $display("FAIL idle_no_chars: got %0d required 0", t_q.size() - n_rx); end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL idle_ocupado: got %b required 0", ocupado); end
    endtask

    initial begin
        fork
            decodificador();
        join_none
        test_reset();
        test_cambio();
        test_cambios_en_linea();
        test_habilitar();
        test_reset_linea();
        test_reposo_largo();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
